bpsk_symbol_mod: RTL and testbench
==================================

# bpsk_symbol_mod

Binary phase-shift-keying symbol modulator placed directly downstream of the DDS datapath. Consumes the DDS 9-bit signed sine carrier one sample per cycle, accepts a serial bit stream through a valid/ready handshake into a small FIFO, and holds each bit for a fixed number of carrier samples. Passes the carrier unchanged for a 0 symbol and negates it for a 1 symbol, producing the modulated 9-bit output for the DAC/output stage.

## Interface
- SAMPLES_PER_SYM, 16, carrier samples per symbol; legal range 2..256.
- FIFO_DEPTH, 4, bit FIFO entries; power of two, at least 2.

- clk  input  1  rising-edge clock shared with the DDS.
- rst  input  1  synchronous, active-high reset.
- sample_in  input  9  signed two's-complement carrier sample from the DDS.
- sample_valid  input  1  sample_in is valid this cycle.
- bit_in  input  1  data bit to transmit.
- bit_valid  input  1  bit_in offered.
- bit_ready  output  1  FIFO can accept a bit; equals !full.
- mod_out  output  9  signed modulated sample, registered.
- out_valid  output  1  mod_out valid; registered copy of sample_valid.
- out_last  output  1  one-cycle pulse with the final sample of the final queued symbol.
- busy  output  1  high while in RUN.

## Operation
- FIFO push: on bit_valid && bit_ready. Pop: only at a symbol start, and only if non-empty before the edge. A bit pushed into an empty FIFO is poppable the following cycle, never the same cycle. When full, bit_ready=0 even if a pop occurs that cycle.
- State IDLE: mod_out=0 on every valid sample, sym_cnt=0. On a cycle with sample_valid && FIFO non-empty: pop the bit, load it as the current symbol, go to RUN. This sample is modulated with the popped bit.
- State RUN: on each sample_valid, output the modulated sample and increment sym_cnt. At sym_cnt==SAMPLES_PER_SYM-1 with sample_valid:
  - FIFO non-empty: pop the next bit; sym_cnt=0; stay in RUN.
  - FIFO empty: go to IDLE; assert out_last with this sample.
  - Cycles without sample_valid freeze the state, counter, and FIFO pop logic.
- Modulation:
  - Symbol 0: mod_out = sample_in.
  - Symbol 1: mod_out = -sample_in, 9-bit.
  - Negating -256 saturates to +255; no other clipping.
  - The symbol takes effect on the first sample of its period. Sample boundaries are exact, with no phase re-alignment of the carrier.

## Timing
- Reset: mod_out=0, out_valid=0, out_last=0, busy=0, bit_ready=1, FIFO empty, sym_cnt=0, state IDLE, differential reference=0.
- Latency: sample_in on cycle N appears on mod_out and out_valid in cycle N+1.
- busy rises the cycle after the IDLE→RUN edge. It falls the cycle after the edge carrying out_last.
- Reset asserted mid-symbol takes priority over every other event. FIFO contents are discarded, and the next cycle's outputs are the reset values.
- Each symbol lasts exactly SAMPLES_PER_SYM valid samples. Throughput is one bit per SAMPLES_PER_SYM valid samples, with back-to-back symbols and no gap when the FIFO stays non-empty.

## Configuration
- DIFF_ENCODE_EN defined: differential BPSK. Transmitted symbol = popped bit XOR previous transmitted symbol.
  - The reference symbol resets to 0 on rst and on every RUN→IDLE transition.
  - The first symbol of a burst is therefore the raw bit.
- DIFF_ENCODE_EN undefined: transmitted symbol = popped bit. There is no reference register.

## Test plan
- Basic modulation, SAMPLES_PER_SYM=4, sample_valid held high, sample_in ramp 10,20,…:
  - Push bits 0,1.
  - Output: 8 modulated samples. The first 4 pass through; the next 4 are negated (e.g. 50→-50).
  - out_last is asserted on the 8th sample, then mod_out=0.
- Saturation: symbol 1 active, sample_in=-256 (9'h100) → mod_out=+255 (9'h0FF). sample_in=+255 → -255.
- Backpressure, FIFO_DEPTH=4:
  - Push 5 bits in IDLE with sample_valid=0. bit_ready drops after the 4th, and the 5th is held.
  - Enable samples: the 5th bit is accepted the cycle after the first pop.
- Stalled samples: toggle sample_valid 1,0,1,0 within a symbol. sym_cnt and out_valid track only valid cycles, and the symbol still spans exactly SAMPLES_PER_SYM outputs.
- Reset mid-operation: assert rst at sample 2 of a 1-symbol with 3 bits queued. The next cycle shows mod_out=0, busy=0, bit_ready=1, and no further symbols are transmitted.
- DIFF_ENCODE_EN: push bits 1,1,0 → transmitted symbols 1,0,0 (polarities negated, pass, pass). After returning to IDLE, bit 1 → negated.

Source files
------------

// File: rtl/bpsk_symbol_mod.sv
// BPSK symbol modulator: bit FIFO feeding a per-symbol carrier negation stage.
// Define DIFF_ENCODE_EN for differential encoding against the previously transmitted symbol.
module bpsk_symbol_mod #(
    parameter int unsigned SAMPLES_PER_SYM = 16,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [8:0] sample_in,
    input  logic              sample_valid,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    output logic signed [8:0] mod_out,
    output logic              out_valid,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned CW = $clog2(SAMPLES_PER_SYM);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLES_PER_SYM - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sym_q, sym_d;
    logic [8:0]        mod_q, mod_d;
    logic              valid_q;
    logic              last_q, last_d;
    logic [FIFO_DEPTH-1:0] fifo_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW:0]       count_q;
    logic              fifo_empty, push, pop, tx_bit, use_sym, active;
`ifdef DIFF_ENCODE_EN
    logic              ref_q, ref_d;
`endif

    function automatic logic [8:0] neg_sat(input logic [8:0] s);
        // -(-256) does not fit in 9 bits; clamp to +255
        return (s == 9'h100) ? 9'h0FF : 9'(~s + 9'd1);
    endfunction

    assign fifo_empty = (count_q == '0);
    assign bit_ready  = (count_q != FULL_CNT);
    assign push       = bit_valid && bit_ready;

`ifdef DIFF_ENCODE_EN
    assign tx_bit = fifo_q[rd_ptr_q] ^ ref_q;
`else
    assign tx_bit = fifo_q[rd_ptr_q];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        mod_d   = mod_q;
        last_d  = 1'b0;
        pop     = 1'b0;
        active  = 1'b0;
        use_sym = sym_q;
`ifdef DIFF_ENCODE_EN
        ref_d   = ref_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sample_valid && !fifo_empty) begin
                    // popped bit modulates this same sample, so it counts as sample 0
                    pop     = 1'b1;
                    active  = 1'b1;
                    sym_d   = tx_bit;
                    use_sym = tx_bit;
                    cnt_d   = CW'(1);
                    state_d = RUN;
`ifdef DIFF_ENCODE_EN
                    ref_d   = tx_bit;
`endif
                end
            end
            RUN: begin
                if (sample_valid) begin
                    active = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (!fifo_empty) begin
                            pop   = 1'b1;
                            sym_d = tx_bit;
`ifdef DIFF_ENCODE_EN
                            ref_d = tx_bit;
`endif
                        end else begin
                            state_d = IDLE;
                            last_d  = 1'b1;
`ifdef DIFF_ENCODE_EN
                            ref_d   = 1'b0;
`endif
                        end
                    end else begin
                        cnt_d = CW'(cnt_q + 1'b1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (sample_valid) begin
            mod_d = active ? (use_sym ? neg_sat(sample_in) : sample_in) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sym_q    <= 1'b0;
            mod_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef DIFF_ENCODE_EN
            ref_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            mod_q   <= mod_d;
            valid_q <= sample_valid;
            last_q  <= last_d;
`ifdef DIFF_ENCODE_EN
            ref_q   <= ref_d;
`endif
            if (push) begin
                fifo_q[wr_ptr_q] <= bit_in;
                wr_ptr_q         <= PW'(wr_ptr_q + 1'b1);
            end
            if (pop) begin
                rd_ptr_q <= PW'(rd_ptr_q + 1'b1);
            end
            case ({push, pop})
                2'b10:   count_q <= (PW + 1)'(count_q + 1'b1);
                2'b01:   count_q <= (PW + 1)'(count_q - 1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign mod_out   = mod_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_bpsk_symbol_mod.sv
// Directed bench for bpsk_symbol_mod with SAMPLES_PER_SYM=4, FIFO_DEPTH=4.
// Expectations for the final burst depend on DIFF_ENCODE_EN.
module tb_bpsk_symbol_mod;

    logic              clk;
    logic              rst;
    logic signed [8:0] sample_in;
    logic              sample_valid;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic signed [8:0] mod_out;
    logic              out_valid;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    bpsk_symbol_mod #(
        .SAMPLES_PER_SYM(4),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .mod_out     (mod_out),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    function automatic logic [8:0] negv(input int v);
        return 9'(-v);
    endfunction

    logic [4:0] bp;
    logic [3:0] dsym;

    initial begin
        rst = 1'b1; sample_in = '0; sample_valid = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_mod", mod_out, 9'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", bit_ready, 1'b1);

        // basic: bits 0,1 over ramp 10,20,...
        push_bit(1'b0);
        push_bit(1'b1);
        sample_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample_in = 9'(10 * (i + 1));
            tick();
            chk("basic_mod", mod_out, (i < 4) ? 9'(10 * (i + 1)) : negv(10 * (i + 1)));
            chk("basic_valid", out_valid, 1'b1);
            chk("basic_last", out_last, (i == 7));
            chk("basic_busy", busy, (i != 7));
        end
        sample_in = 9'sd90;
        tick();
        chk("basic_idle_mod", mod_out, 9'd0);
        chk("basic_idle_last", out_last, 1'b0);
        sample_valid = 1'b0;

        // saturation on symbol 1
        push_bit(1'b1);
        sample_valid = 1'b1;
        sample_in = 9'sh100; tick(); chk("sat_m256", mod_out, 9'h0FF);
        sample_in = 9'sd255; tick(); chk("sat_p255", mod_out, 9'h101);
        sample_in = -9'sd255; tick(); chk("sat_m255", mod_out, 9'h0FF);
        sample_in = 9'sd0;   tick(); chk("sat_zero", mod_out, 9'h000);
        chk("sat_last", out_last, 1'b1);
        sample_valid = 1'b0;
        tick();

        // backpressure: 5 bits offered with samples stalled
        bp = 5'b01101;
        bit_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit_in = bp[k];
            tick();
            chk("bp_ready_fill", bit_ready, (k < 3));
        end
        bit_in = bp[4];
        tick();
        chk("bp_ready_held", bit_ready, 1'b0);
        sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_in = 9'(i + 1);
            tick();
            if (i == 0) chk("bp_ready_after_pop", bit_ready, 1'b1);
            if (i == 1) begin
                chk("bp_ready_refull", bit_ready, 1'b0);
                bit_valid = 1'b0;
            end
            chk("bp_mod", mod_out, bp[i / 4] ? negv(i + 1) : 9'(i + 1));
            chk("bp_last", out_last, (i == 19));
        end
        sample_valid = 1'b0;
        tick();

        // stalled samples within one symbol
        push_bit(1'b1);
        for (int c = 0; c < 8; c++) begin
            sample_valid = (c % 2 == 0);
            sample_in    = 9'(11 + c);
            tick();
            chk("stall_valid", out_valid, (c % 2 == 0));
            if (c % 2 == 0) chk("stall_mod", mod_out, negv(11 + c));
            chk("stall_last", out_last, (c == 6));
            chk("stall_busy", busy, (c < 6));
        end
        sample_valid = 1'b1;
        sample_in = 9'sd40;
        tick();
        chk("stall_idle_mod", mod_out, 9'd0);
        sample_valid = 1'b0;

        // reset mid-symbol with 3 bits queued
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b1);
        sample_valid = 1'b1;
        sample_in = 9'sd20; tick(); chk("rm_s0", mod_out, negv(20));
        sample_in = 9'sd21; tick(); chk("rm_s1", mod_out, negv(21));
        rst = 1'b1;
        sample_in = 9'sd22; tick();
        rst = 1'b0;
        chk("rm_mod", mod_out, 9'd0);
        chk("rm_busy", busy, 1'b0);
        chk("rm_ready", bit_ready, 1'b1);
        chk("rm_valid", out_valid, 1'b0);
        chk("rm_last", out_last, 1'b0);
        for (int i = 0; i < 12; i++) begin
            sample_in = 9'(30 + i);
            tick();
            chk("rm_after_mod", mod_out, 9'd0);
            chk("rm_after_busy", busy, 1'b0);
        end
        sample_valid = 1'b0;
        tick();

        // bits 1,1,0 then, after IDLE, bit 1
`ifdef DIFF_ENCODE_EN
        dsym = 4'b1001;
`else
        dsym = 4'b1011;
`endif
        push_bit(1'b1); push_bit(1'b1); push_bit(1'b0);
        sample_valid = 1'b1;
        sample_in = 9'sd5;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("enc_mod", mod_out, dsym[i / 4] ? negv(5) : 9'd5);
            chk("enc_last", out_last, (i == 11));
        end
        sample_valid = 1'b0;
        push_bit(1'b1);
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("enc2_mod", mod_out, dsym[3] ? negv(5) : 9'd5);
            chk("enc2_last", out_last, (i == 3));
        end
        sample_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
